// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: bus width, register map,
// reset constants, port FSM encoding and the byte-strobe merge helper.
package clint_pkg;

  localparam int DataBus_WIDTH = 64;

  localparam logic [DataBus_WIDTH-1:0] CLINT_MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
  localparam logic [DataBus_WIDTH-1:0] CLINT_MTIMECMP_ADDR = 64'h0000_0000_0200_4000;
  localparam logic [DataBus_WIDTH-1:0] CLINT_MTIMECMP_RST  = '1;

  typedef enum logic {
    CLINT_IDLE = 1'b0,
    CLINT_RESP = 1'b1
  } clint_state_e;

  // Replace the bytes of old_val selected by strb with the matching bytes of wdata.
  function automatic logic [DataBus_WIDTH-1:0] clint_merge(
    input logic [DataBus_WIDTH-1:0]   old_val,
    input logic [DataBus_WIDTH-1:0]   wdata,
    input logic [DataBus_WIDTH/8-1:0] strb
  );
    logic [DataBus_WIDTH-1:0] res;
    res = old_val;
    for (int k = 0; k < DataBus_WIDTH / 8; k++) begin
      if (strb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator for mtime: one-cycle pulse every TICK_DIV clocks.
// With TICK_DIV = 1 the count never leaves 0, so the tick is held high.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: free-running mtime, mtimecmp compare, machine timer
// interrupt request and a single-outstanding request/response register port.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned                TICK_DIV      = 1,
  parameter logic [DataBus_WIDTH-1:0]   MTIME_ADDR    = CLINT_MTIME_ADDR,
  parameter logic [DataBus_WIDTH-1:0]   MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR
) (
  input  logic                         clint_clk_i,
  input  logic                         clint_rst_n_i,
  input  logic                         clint_req_valid_i,
  output logic                         clint_req_ready_o,
  input  logic                         clint_req_wen_i,
  input  logic [DataBus_WIDTH-1:0]     clint_req_addr_i,
  input  logic [DataBus_WIDTH-1:0]     clint_req_wdata_i,
  input  logic [DataBus_WIDTH/8-1:0]   clint_req_wstrb_i,
  output logic                         clint_resp_valid_o,
  input  logic                         clint_resp_ready_i,
  output logic [DataBus_WIDTH-1:0]     clint_resp_rdata_o,
  output logic                         clint_resp_err_o,
  input  logic                         clint_mstatus_mie_i,
  input  logic                         clint_mie_mtie_i,
  output logic                         clint_mtip_o,
  output logic                         clint_timer_intr_o,
  output clint_state_e                 clint_dbg_state_o
);

  logic                     tick;
  logic [DataBus_WIDTH-1:0] mtime_q,    mtime_d;
  logic [DataBus_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
  logic                     mtip_q,     mtip_d;
  logic                     intr_q,     intr_d;

  clint_state_e             state_q;
  logic                     ready_q;
  logic                     resp_valid_q;
  logic [DataBus_WIDTH-1:0] rdata_q;
  logic                     err_q;

  logic accept;
  logic addr_aligned;
  logic hit_mtime;
  logic hit_mtimecmp;
  logic addr_err;
  logic wr_mtime;
  logic wr_mtimecmp;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i   (clint_clk_i),
    .rst_n_i (clint_rst_n_i),
    .tick_o  (tick)
  );

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high; the response transfers on a rising edge where resp_valid and
  // resp_ready are both high. rdata/err stay stable while resp_valid waits.
  assign accept       = clint_req_valid_i & ready_q;
  assign addr_aligned = (clint_req_addr_i[2:0] == 3'b000);
  assign hit_mtime    = addr_aligned & (clint_req_addr_i == MTIME_ADDR);
  assign hit_mtimecmp = addr_aligned & (clint_req_addr_i == MTIMECMP_ADDR);
  assign addr_err     = ~(hit_mtime | hit_mtimecmp);
  assign wr_mtime     = accept & clint_req_wen_i & hit_mtime;
  assign wr_mtimecmp  = accept & clint_req_wen_i & hit_mtimecmp;

  // A software write to mtime overrides the tick increment on the same edge.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime) begin
      mtime_d = clint_merge(mtime_q, clint_req_wdata_i, clint_req_wstrb_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    mtimecmp_d = mtimecmp_q;
    if (wr_mtimecmp) begin
      mtimecmp_d = clint_merge(mtimecmp_q, clint_req_wdata_i, clint_req_wstrb_i);
    end
    mtip_d = (mtime_q >= mtimecmp_q);
    intr_d = mtip_d & clint_mstatus_mie_i & clint_mie_mtie_i;
  end

  always_ff @(posedge clint_clk_i or negedge clint_rst_n_i) begin
    if (!clint_rst_n_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= CLINT_MTIMECMP_RST;
      mtip_q     <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
      intr_q     <= intr_d;
    end
  end

  // Port FSM; read data is the register value before this edge's update.
  always_ff @(posedge clint_clk_i or negedge clint_rst_n_i) begin
    if (!clint_rst_n_i) begin
      state_q      <= CLINT_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        CLINT_IDLE: begin
          if (accept) begin
            state_q      <= CLINT_RESP;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= addr_err;
            if (clint_req_wen_i || addr_err) begin
              rdata_q <= '0;
            end else if (hit_mtime) begin
              rdata_q <= mtime_q;
            end else begin
              rdata_q <= mtimecmp_q;
            end
          end
        end
        CLINT_RESP: begin
          if (clint_resp_ready_i) begin
            state_q      <= CLINT_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
          end
        end
        default: begin
          state_q      <= CLINT_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign clint_req_ready_o  = ready_q;
  assign clint_resp_valid_o = resp_valid_q;
  assign clint_resp_rdata_o = rdata_q;
  assign clint_resp_err_o   = err_q;
  assign clint_mtip_o       = mtip_q;
  assign clint_timer_intr_o = intr_q;
  assign clint_dbg_state_o  = state_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV = 1 and 3) share one request stream
// and are checked against an edge-count based model of mtime/mtimecmp.
module tb_clint;
  import clint_pkg::*;

  localparam logic [63:0] MT  = CLINT_MTIME_ADDR;
  localparam logic [63:0] CMP = CLINT_MTIMECMP_ADDR;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_wen   = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_ready = 1'b0;
  logic        mie  = 1'b0;
  logic        mtie = 1'b0;

  logic [1:0]   ready_o, resp_valid_o, err_o, mtip_o, intr_o;
  logic [63:0]  rdata_o [2];
  clint_state_e st_o [2];

  clint #(.TICK_DIV(1)) u_dut1 (
    .clint_clk_i (clk), .clint_rst_n_i (rst_n),
    .clint_req_valid_i (req_valid), .clint_req_ready_o (ready_o[0]),
    .clint_req_wen_i (req_wen), .clint_req_addr_i (req_addr),
    .clint_req_wdata_i (req_wdata), .clint_req_wstrb_i (req_wstrb),
    .clint_resp_valid_o (resp_valid_o[0]), .clint_resp_ready_i (resp_ready),
    .clint_resp_rdata_o (rdata_o[0]), .clint_resp_err_o (err_o[0]),
    .clint_mstatus_mie_i (mie), .clint_mie_mtie_i (mtie),
    .clint_mtip_o (mtip_o[0]), .clint_timer_intr_o (intr_o[0]),
    .clint_dbg_state_o (st_o[0])
  );

  clint #(.TICK_DIV(3)) u_dut3 (
    .clint_clk_i (clk), .clint_rst_n_i (rst_n),
    .clint_req_valid_i (req_valid), .clint_req_ready_o (ready_o[1]),
    .clint_req_wen_i (req_wen), .clint_req_addr_i (req_addr),
    .clint_req_wdata_i (req_wdata), .clint_req_wstrb_i (req_wstrb),
    .clint_resp_valid_o (resp_valid_o[1]), .clint_resp_ready_i (resp_ready),
    .clint_resp_rdata_o (rdata_o[1]), .clint_resp_err_o (err_o[1]),
    .clint_mstatus_mie_i (mie), .clint_mie_mtie_i (mtie),
    .clint_mtip_o (mtip_o[1]), .clint_timer_intr_o (intr_o[1]),
    .clint_dbg_state_o (st_o[1])
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Entry: {err, rdata for TICK_DIV=3, rdata for TICK_DIV=1}
  logic [128:0] exp_q[$];

  int unsigned div_c [2] = '{1, 3};
  int unsigned edge_cnt;
  int unsigned m_wedge [2];
  logic [63:0] m_base  [2];
  logic [63:0] m_mt    [2];
  logic [63:0] m_cmp   [2];
  logic        m_exp_mtip [2];
  logic        m_exp_intr [2];
  logic        m_busy;
  logic        m_accepted;

  task automatic chk(input string name, input int j, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, j, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_merge(input logic [63:0] old_v, input logic [63:0] nw,
                                            input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int k = 0; k < 8; k++) if (strb[k]) mask = mask | (64'hFF << (8 * k));
    return (old_v & ~mask) | (nw & mask);
  endfunction

  // ---------------- reference model ----------------
  // mtime after edge e = value written at edge w + (ticks in (w, e]),
  // where a tick occurs on every edge whose index is a multiple of TICK_DIV.
  initial begin
    forever begin
      logic        acc, hit_mt, hit_cmp, err;
      logic [63:0] rd [2];
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_cnt   = 0;
        m_busy     = 1'b0;
        m_accepted = 1'b0;
        exp_q.delete();
        for (int j = 0; j < 2; j++) begin
          m_wedge[j] = 0;
          m_base[j]  = '0;
          m_mt[j]    = '0;
          m_cmp[j]   = '1;
          m_exp_mtip[j] = 1'b0;
          m_exp_intr[j] = 1'b0;
        end
      end else begin
        edge_cnt++;
        acc     = req_valid && !m_busy;
        hit_mt  = (req_addr == MT);
        hit_cmp = (req_addr == CMP);
        err     = !(hit_mt || hit_cmp);
        for (int j = 0; j < 2; j++) begin
          m_exp_mtip[j] = (m_mt[j] >= m_cmp[j]);
          m_exp_intr[j] = m_exp_mtip[j] && mie && mtie;
          rd[j] = (req_wen || err) ? 64'd0 : (hit_mt ? m_mt[j] : m_cmp[j]);
          if (acc && req_wen && hit_mt) begin
            m_base[j]  = ref_merge(m_mt[j], req_wdata, req_wstrb);
            m_wedge[j] = edge_cnt;
          end
          if (acc && req_wen && hit_cmp) m_cmp[j] = ref_merge(m_cmp[j], req_wdata, req_wstrb);
          m_mt[j] = m_base[j] + 64'(edge_cnt / div_c[j]) - 64'(m_wedge[j] / div_c[j]);
        end
        if (acc) exp_q.push_back({err, rd[1], rd[0]});
        if (m_busy && resp_ready) m_busy = 1'b0;
        else if (acc)             m_busy = 1'b1;
        m_accepted = acc;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      logic [128:0] e;
      @(negedge clk);
      if (rst_n) begin
        for (int j = 0; j < 2; j++) begin
          chk("req_ready",  j, 65'(ready_o[j]), 65'(!m_busy));
          chk("resp_valid", j, 65'(resp_valid_o[j]), 65'(m_busy));
          chk("fsm_state",  j, 65'(st_o[j]), 65'(m_busy ? CLINT_RESP : CLINT_IDLE));
          chk("mtip",       j, 65'(mtip_o[j]), 65'(m_exp_mtip[j]));
          chk("timer_intr", j, 65'(intr_o[j]), 65'(m_exp_intr[j]));
        end
        if (resp_valid_o != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 0, 65'(resp_valid_o), 65'd0);
          end else begin
            e = exp_q[0];
            for (int j = 0; j < 2; j++) begin
              if (resp_valid_o[j]) chk("resp_err_rdata", j, {err_o[j], rdata_o[j]}, {e[128], e[64*j +: 64]});
            end
            if (resp_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb, input int hold);
    int n;
    @(posedge clk); #2;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    resp_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_accepted && n < 20);
    if (!m_accepted) chk("accept_timeout", 0, 65'd0, 65'd1);
    #1;
    req_valid = 1'b0;
    repeat (hold) @(posedge clk);
    #2;
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
  endtask

  task automatic set_en(input logic new_mie, input logic new_mtie);
    @(posedge clk); #2;
    mie = new_mie; mtie = new_mtie;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // idle, then read mtime
    idle(5);
    do_req(1'b0, MT, 64'd0, 8'h00, 0);

    // compare and interrupt
    set_en(1'b1, 1'b1);
    do_req(1'b1, CMP, 64'h20, 8'hFF, 0);
    idle(110);
    do_req(1'b1, CMP, 64'h1000, 8'hFF, 0);
    idle(3);

    // enable gating with mtip high
    do_req(1'b1, CMP, 64'h0, 8'hFF, 0);
    set_en(1'b0, 1'b1);
    idle(4);
    set_en(1'b1, 1'b1);
    idle(4);
    set_en(1'b1, 1'b0);
    idle(3);

    // byte strobes
    do_req(1'b1, MT, 64'h100, 8'hFF, 0);
    do_req(1'b1, MT, 64'h1122_3344_5566_7788, 8'h0F, 0);
    do_req(1'b0, MT, 64'd0, 8'h00, 0);
    do_req(1'b1, MT, 64'hDEAD_BEEF_0000_0000, 8'h00, 1);
    do_req(1'b0, MT, 64'd0, 8'h00, 0);

    // errors and backpressure
    do_req(1'b0, 64'h0200_4004, 64'd0, 8'h00, 4);
    do_req(1'b1, 64'h0200_4004, 64'h5A5A, 8'hFF, 2);
    do_req(1'b1, MT + 64'd1, 64'h5A5A, 8'hFF, 0);
    do_req(1'b0, CMP, 64'd0, 8'h00, 3);

    // wrap
    do_req(1'b1, MT, '1, 8'hFF, 0);
    idle(3);
    do_req(1'b0, MT, 64'd0, 8'h00, 0);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = MT;
        2, 3:    a = CMP;
        default: a = ($urandom_range(0, 1) == 0) ? (MT + 64'(4 * $urandom_range(1, 2)))
                                                  : {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) set_en(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_req(1'($urandom_range(0, 1)), a,
             ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 400)),
             8'($urandom_range(0, 255)), $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    // reset while a response is pending
    @(posedge clk); #2;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = MT; resp_ready = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk("rst_resp_valid", j, 65'(resp_valid_o[j]), 65'd0);
      chk("rst_req_ready",  j, 65'(ready_o[j]), 65'd1);
      chk("rst_mtip",       j, 65'(mtip_o[j]), 65'd0);
      chk("rst_timer_intr", j, 65'(intr_o[j]), 65'd0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(4);
    do_req(1'b0, MT, 64'd0, 8'h00, 0);
    do_req(1'b0, CMP, 64'd0, 8'h00, 0);
    idle(3);

    if (exp_q.size() != 0) chk("queue_drained", 0, 65'(exp_q.size()), 65'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
